fma_align_pipe: RTL

Parametrised, two-stage pipelined alignment shifter for the FMA datapath. Positions the addend fraction Z relative to the multiplier product, produces exact addend and product sticky bits and the kill-product flag, and supports the pre-rounded bypass increment. It sits between the exponent/alignment-count logic and the FMA adder, and uses a valid/ready handshake with flush so the FMA can stall or squash in-flight operations.

---
 rtl/fma_align_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fma_align_pipe.sv
// fma_align_pipe: two-stage alignment shifter for the FMA datapath.
// Stage 1 selects the (optionally incremented) addend fraction and classifies
// the alignment count; stage 2 builds the base word, shifts it and derives the
// exact sticky bits. A valid/ready handshake with flush lets the FMA stall or
// squash in-flight operations.
module fma_align_pipe #(
   parameter int NF   = 52,
   parameter int NC   = 12,
   parameter int TAGW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [NF-1:0]     z,
   input  logic [NC-1:0]     aligncnt,
   input  logic              ae_neg,
   input  logic              xzero,
   input  logic              yzero,
   input  logic              zzero,
   input  logic              byp_plus1,
   input  logic              byp_postnorm,
   input  logic              byp_sel,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3*NF+1:0]   t,
   output logic              bs,
   output logic              ps,
   output logic              killprod,
   output logic [TAGW-1:0]   out_tag
);

   localparam int TW  = 3 * NF + 2;
   // Largest shift that reaches the datapath is 2*NF (right shift).
   localparam int SHW = $clog2(2 * NF + 1);

   localparam logic signed [NC-1:0] CNT_HI = NC'(NF + 1);
   localparam logic signed [NC-1:0] CNT_LO = NC'(-2 * NF);

   // Case codes resolved in stage 1, consumed by the stage-2 shifter.
   typedef enum logic [2:0] {
      C_ZERO  = 3'd0,   // addend is zero
      C_KILL  = 3'd1,   // addend dominates, product dropped
      C_UNDER = 3'd2,   // addend entirely below the sticky range
      C_LEFT  = 3'd3,   // left shift by sh
      C_RIGHT = 3'd4    // right shift by sh with exact sticky
   } case_e;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s2_load;
   logic s1_adv;
   logic s1_load;

   assign s2_load  = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_load;
   assign in_ready = s1_adv;
   assign s1_load  = in_valid & in_ready & ~flush;

   // ---------------------------------------------------------------------
   // Stage 1: fraction select and case classification
   // ---------------------------------------------------------------------
   logic [NF:0]            z1;
   logic [NF-1:0]          z2_in;
   logic signed [NC-1:0]   cnt_s;
   logic signed [NC-1:0]   cnt_neg;
   case_e                  code_in;
   logic [SHW-1:0]         sh_in;

   assign cnt_s   = aligncnt;
   assign cnt_neg = -cnt_s;

   // Pick z2 and classify aligncnt in priority order.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      z1      = {1'b0, z} + {{NF{1'b0}}, 1'b1};
      z2_in   = z;
      code_in = C_RIGHT;
      sh_in   = cnt_neg[SHW-1:0];
      if (byp_sel & byp_plus1) begin
         z2_in = byp_postnorm ? z1[NF:1] : z1[NF-1:0];
      end
      if (zzero) begin
         code_in = C_ZERO;
         sh_in   = '0;
      end else if ((cnt_s > CNT_HI) || xzero || yzero) begin
         code_in = C_KILL;
         sh_in   = '0;
      end else if (ae_neg && (cnt_s < CNT_LO)) begin
         code_in = C_KILL;
         sh_in   = '0;
      end else if (cnt_s < CNT_LO) begin
         code_in = C_UNDER;
         sh_in   = '0;
      end else if (!cnt_s[NC-1]) begin
         code_in = C_LEFT;
         sh_in   = cnt_s[SHW-1:0];
      end
   end

   logic [NF-1:0]   s1_z2_q,     s1_z2_d;
   case_e           s1_code_q,   s1_code_d;
   logic [SHW-1:0]  s1_sh_q,     s1_sh_d;
   logic            s1_zzero_q,  s1_zzero_d;
   logic            s1_xyzero_q, s1_xyzero_d;
   logic [TAGW-1:0] s1_tag_q,    s1_tag_d;

   // Stage-1 next state: load on an accepted input, otherwise hold.
   always_comb begin
      // NOTE: combinational logic uses blocking assignments so later lines
      // see the values computed above them.
      s1_valid_d  = flush ? 1'b0 : (s1_adv ? in_valid : s1_valid_q);
      s1_z2_d     = s1_z2_q;
      s1_code_d   = s1_code_q;
      s1_sh_d     = s1_sh_q;
      s1_zzero_d  = s1_zzero_q;
      s1_xyzero_d = s1_xyzero_q;
      s1_tag_d    = s1_tag_q;
      if (s1_load) begin
         s1_z2_d     = z2_in;
         s1_code_d   = code_in;
         s1_sh_d     = sh_in;
         s1_zzero_d  = zzero;
         s1_xyzero_d = xzero | yzero;
         s1_tag_d    = in_tag;
      end
   end

   // Stage-1 registers.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_z2_q     <= '0;
         s1_code_q   <= C_ZERO;
         s1_sh_q     <= '0;
         s1_zzero_q  <= 1'b0;
         s1_xyzero_q <= 1'b0;
         s1_tag_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_z2_q     <= s1_z2_d;
         s1_code_q   <= s1_code_d;
         s1_sh_q     <= s1_sh_d;
         s1_zzero_q  <= s1_zzero_d;
         s1_xyzero_q <= s1_xyzero_d;
         s1_tag_q    <= s1_tag_d;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: build base word, shift, exact sticky
   // ---------------------------------------------------------------------
   logic [TW-1:0] b;
   logic [TW-1:0] low_mask;
   logic [TW-1:0] t_new;
   logic          bs_new, ps_new, kill_new;

   // Leading one sits at bit 2*NF; the low NF bits of b are always zero.
   assign b        = {{(NF + 1){1'b0}}, ~s1_zzero_q, s1_z2_q, {NF{1'b0}}};
   assign low_mask = ~({TW{1'b1}} << s1_sh_q);

   // Result of the classified case.
   always_comb begin
      t_new    = '0;
      bs_new   = 1'b0;
      ps_new   = 1'b0;
      kill_new = 1'b0;
      unique case (s1_code_q)
         C_ZERO: begin
            kill_new = s1_xyzero_q;
         end
         C_KILL: begin
            t_new    = b;
            kill_new = 1'b1;
            ps_new   = ~s1_xyzero_q;
         end
         C_UNDER: begin
            bs_new = 1'b1;
         end
         C_LEFT: begin
            t_new = b << s1_sh_q;
         end
         C_RIGHT: begin
            t_new  = b >> s1_sh_q;
            bs_new = |(b & low_mask);
         end
         default: begin
            t_new = '0;
         end
      endcase
   end

   logic [TW-1:0]   t_q,    t_d;
   logic            bs_q,   bs_d;
   logic            ps_q,   ps_d;
   logic            kill_q, kill_d;
   logic [TAGW-1:0] tag_q,  tag_d;

   // Stage-2 next state: load when the slot is free or being drained.
   always_comb begin
      s2_valid_d = flush ? 1'b0 : (s2_load ? s1_valid_q : s2_valid_q);
      t_d        = t_q;
      bs_d       = bs_q;
      ps_d       = ps_q;
      kill_d     = kill_q;
      tag_d      = tag_q;
      if (s2_load & s1_valid_q) begin
         t_d    = t_new;
         bs_d   = bs_new;
         ps_d   = ps_new;
         kill_d = kill_new;
         tag_d  = s1_tag_q;
      end
   end

   // Stage-2 registers.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: payload flops are reset too, because the outputs must read zero
      // out of reset rather than whatever the flops powered up with.
      if (!reset_n) begin
         s2_valid_q <= 1'b0;
         t_q        <= '0;
         bs_q       <= 1'b0;
         ps_q       <= 1'b0;
         kill_q     <= 1'b0;
         tag_q      <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         t_q        <= t_d;
         bs_q       <= bs_d;
         ps_q       <= ps_d;
         kill_q     <= kill_d;
         tag_q      <= tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign t         = t_q;
   assign bs        = bs_q;
   assign ps        = ps_q;
   assign killprod  = kill_q;
   assign out_tag   = tag_q;

endmodule
